// File: rtl/multicycle_control_unit.sv
// Moore control FSM for the multicycle CPU datapath.
// Drives every write-enable, mux select and ALU op; handles opcode/overflow traps.
module multicycle_control_unit #(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       Overflow,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       RegAWrite,
  output logic       RegBWrite,
  output logic       RegALUOutWrite,
  output logic       RegMDRWrite,
  output logic       RegEPCWrite,
  output logic [1:0] ALUSrcA,
  output logic [2:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] PCSource,
  output logic [1:0] MemAdd,
  output logic [1:0] ExceptionAddress,
  output logic [2:0] RegDest,
  output logic [3:0] RegData
);

  typedef enum logic [4:0] {
    S_RESET, S_FETCH, S_FETCH_LATCH, S_DECODE,
    S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I,
    S_ADDR, S_MEM_RD, S_WB_L, S_MEM_WR,
    S_BEQ, S_JUMP, S_EXC, S_EXC_RD, S_EXC_JMP
  } state_t;

  typedef struct packed {
    logic       pc_wr;
    logic       ir_wr;
    logic       mem_wr;
    logic       reg_wr;
    logic       a_wr;
    logic       b_wr;
    logic       aluout_wr;
    logic       mdr_wr;
    logic       epc_wr;
    logic [1:0] src_a;
    logic [2:0] src_b;
    logic [2:0] alu_op;
    logic [2:0] pc_src;
    logic [1:0] mem_add;
    logic [1:0] exc_addr;
    logic [2:0] reg_dest;
    logic [3:0] reg_data;
  } ctrl_t;

  localparam logic [1:0] WAIT_LD = 2'(MEM_WAIT);

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       cause_q, cause_d;
  ctrl_t      ctrl_q, ctrl_d;

  logic is_add, is_sub, is_and, is_r;
  logic is_addi, is_lw, is_sw, is_beq, is_j;

  always_comb begin
    is_add  = (Opcode == 6'h00) && (Funct == 6'h20);
    is_sub  = (Opcode == 6'h00) && (Funct == 6'h22);
    is_and  = (Opcode == 6'h00) && (Funct == 6'h24);
    is_r    = is_add || is_sub || is_and;
    is_addi = (Opcode == 6'h08);
    is_lw   = (Opcode == 6'h23);
    is_sw   = (Opcode == 6'h2B);
    is_beq  = (Opcode == 6'h04);
    is_j    = (Opcode == 6'h02);
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    unique case (state_q)
      S_RESET:       state_d = S_FETCH;
      S_FETCH:       if (cnt_q == 2'd0) state_d = S_FETCH_LATCH;
      S_FETCH_LATCH: state_d = S_DECODE;
      S_DECODE: begin
        if (is_r)                 state_d = S_EXEC_R;
        else if (is_addi)         state_d = S_EXEC_I;
        else if (is_lw || is_sw)  state_d = S_ADDR;
        else if (is_beq)          state_d = S_BEQ;
        else if (is_j)            state_d = S_JUMP;
        else begin
          state_d = S_EXC;
          cause_d = 1'b0;
        end
      end
      S_EXEC_R: begin
        if (Overflow && !is_and) begin
          state_d = S_EXC;
          cause_d = 1'b1;
        end else begin
          state_d = S_WB_R;
        end
      end
      S_EXEC_I: begin
        if (Overflow) begin
          state_d = S_EXC;
          cause_d = 1'b1;
        end else begin
          state_d = S_WB_I;
        end
      end
      S_ADDR:    state_d = is_sw ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:  if (cnt_q == 2'd0) state_d = S_WB_L;
      S_EXC:     state_d = S_EXC_RD;
      S_EXC_RD:  if (cnt_q == 2'd0) state_d = S_EXC_JMP;
      S_WB_R, S_WB_I, S_WB_L, S_MEM_WR,
      S_BEQ, S_JUMP, S_EXC_JMP:
                 state_d = S_FETCH;
      default:   state_d = S_RESET;
    endcase
  end

  // Counter reloads on entry to a memory state and counts down while held.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q &&
        (state_d == S_FETCH || state_d == S_MEM_RD ||
         state_d == S_EXC_RD))
      cnt_d = WAIT_LD;
    else if (state_d == state_q && cnt_q != 2'd0)
      cnt_d = cnt_q - 2'd1;
  end

  always_comb begin
    ctrl_d = '0;
    unique case (state_d)
      S_FETCH_LATCH: begin
        ctrl_d.ir_wr  = 1'b1;
        ctrl_d.pc_wr  = 1'b1;
        ctrl_d.src_b  = 3'd1;
        ctrl_d.alu_op = 3'd1;
      end
      S_DECODE: begin
        ctrl_d.a_wr      = 1'b1;
        ctrl_d.b_wr      = 1'b1;
        ctrl_d.aluout_wr = 1'b1;
        ctrl_d.src_b     = 3'd3;
        ctrl_d.alu_op    = 3'd1;
      end
      S_EXEC_R: begin
        ctrl_d.aluout_wr = 1'b1;
        ctrl_d.src_a     = 2'd1;
        ctrl_d.alu_op    = is_sub ? 3'd2 : (is_and ? 3'd3 : 3'd1);
      end
      S_EXEC_I, S_ADDR: begin
        ctrl_d.aluout_wr = 1'b1;
        ctrl_d.src_a     = 2'd1;
        ctrl_d.src_b     = 3'd2;
        ctrl_d.alu_op    = 3'd1;
      end
      S_WB_R: begin
        ctrl_d.reg_wr   = 1'b1;
        ctrl_d.reg_dest = 3'd1;
      end
      S_WB_I: ctrl_d.reg_wr = 1'b1;
      S_MEM_RD: begin
        ctrl_d.mem_add = 2'd1;
        ctrl_d.mdr_wr  = (cnt_d == 2'd0);
      end
      S_WB_L: begin
        ctrl_d.reg_wr   = 1'b1;
        ctrl_d.reg_data = 4'd1;
      end
      S_MEM_WR: begin
        ctrl_d.mem_add = 2'd1;
        ctrl_d.mem_wr  = 1'b1;
      end
      S_BEQ: begin
        ctrl_d.src_a  = 2'd1;
        ctrl_d.alu_op = 3'd2;
        ctrl_d.pc_src = 3'd1;
      end
      S_JUMP: begin
        ctrl_d.pc_wr  = 1'b1;
        ctrl_d.pc_src = 3'd2;
      end
      S_EXC: begin
        ctrl_d.epc_wr   = 1'b1;
        ctrl_d.src_b    = 3'd1;
        ctrl_d.alu_op   = 3'd2;
        ctrl_d.exc_addr = {1'b0, cause_d};
      end
      S_EXC_RD: begin
        ctrl_d.mem_add  = 2'd2;
        ctrl_d.mdr_wr   = (cnt_d == 2'd0);
        ctrl_d.exc_addr = {1'b0, cause_d};
      end
      S_EXC_JMP: begin
        ctrl_d.pc_wr  = 1'b1;
        ctrl_d.pc_src = 3'd3;
      end
      default: ctrl_d = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_RESET;
      cnt_q   <= 2'd0;
      cause_q <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // The branch decision uses this cycle's compare result.
  assign PCWrite          = ctrl_q.pc_wr | ((state_q == S_BEQ) & Zero);
  assign IRWrite          = ctrl_q.ir_wr;
  assign MemWrite         = ctrl_q.mem_wr;
  assign RegWrite         = ctrl_q.reg_wr;
  assign RegAWrite        = ctrl_q.a_wr;
  assign RegBWrite        = ctrl_q.b_wr;
  assign RegALUOutWrite   = ctrl_q.aluout_wr;
  assign RegMDRWrite      = ctrl_q.mdr_wr;
  assign RegEPCWrite      = ctrl_q.epc_wr;
  assign ALUSrcA          = ctrl_q.src_a;
  assign ALUSrcB          = ctrl_q.src_b;
  assign ALUControl       = ctrl_q.alu_op;
  assign PCSource         = ctrl_q.pc_src;
  assign MemAdd           = ctrl_q.mem_add;
  assign ExceptionAddress = ctrl_q.exc_addr;
  assign RegDest          = ctrl_q.reg_dest;
  assign RegData          = ctrl_q.reg_data;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit.
// Two instances: MEM_WAIT=1 (main flows) and MEM_WAIT=2 (lw timing).
module tb_multicycle_control_unit;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] Opcode = 6'h00;
  logic [5:0] Funct = 6'h20;
  logic       Zero = 1'b0;
  logic       Overflow = 1'b0;

  wire [30:0] o1;
  wire [30:0] o2;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  multicycle_control_unit #(.MEM_WAIT(1)) u_dut1 (
    .clock(clock), .reset(reset),
    .Opcode(Opcode), .Funct(Funct),
    .Zero(Zero), .Overflow(Overflow),
    .PCWrite(o1[30]), .IRWrite(o1[29]),
    .MemWrite(o1[28]), .RegWrite(o1[27]),
    .RegAWrite(o1[26]), .RegBWrite(o1[25]),
    .RegALUOutWrite(o1[24]), .RegMDRWrite(o1[23]),
    .RegEPCWrite(o1[22]),
    .ALUSrcA(o1[21:20]), .ALUSrcB(o1[19:17]),
    .ALUControl(o1[16:14]), .PCSource(o1[13:11]),
    .MemAdd(o1[10:9]), .ExceptionAddress(o1[8:7]),
    .RegDest(o1[6:4]), .RegData(o1[3:0])
  );

  multicycle_control_unit #(.MEM_WAIT(2)) u_dut2 (
    .clock(clock), .reset(reset),
    .Opcode(Opcode), .Funct(Funct),
    .Zero(Zero), .Overflow(Overflow),
    .PCWrite(o2[30]), .IRWrite(o2[29]),
    .MemWrite(o2[28]), .RegWrite(o2[27]),
    .RegAWrite(o2[26]), .RegBWrite(o2[25]),
    .RegALUOutWrite(o2[24]), .RegMDRWrite(o2[23]),
    .RegEPCWrite(o2[22]),
    .ALUSrcA(o2[21:20]), .ALUSrcB(o2[19:17]),
    .ALUControl(o2[16:14]), .PCSource(o2[13:11]),
    .MemAdd(o2[10:9]), .ExceptionAddress(o2[8:7]),
    .RegDest(o2[6:4]), .RegData(o2[3:0])
  );

  // we = {PCWr,IRWr,MemWr,RegWr,AWr,BWr,ALUOutWr,MDRWr,EPCWr}
  function automatic logic [30:0] pk(
    input logic [8:0] we, input logic [1:0] sa,
    input logic [2:0] sb, input logic [2:0] op,
    input logic [2:0] ps, input logic [1:0] ma,
    input logic [1:0] ea, input logic [2:0] rd,
    input logic [3:0] rdt);
    return {we, sa, sb, op, ps, ma, ea, rd, rdt};
  endfunction

  localparam logic [30:0] V_ZERO = '0;
  localparam logic [30:0] V_FL =
    pk(9'b110000000, 2'd0, 3'd1, 3'd1, 3'd0, 2'd0, 2'd0, 3'd0, 4'd0);
  localparam logic [30:0] V_DEC =
    pk(9'b000011100, 2'd0, 3'd3, 3'd1, 3'd0, 2'd0, 2'd0, 3'd0, 4'd0);
  localparam logic [30:0] V_EXR_ADD =
    pk(9'b000000100, 2'd1, 3'd0, 3'd1, 3'd0, 2'd0, 2'd0, 3'd0, 4'd0);
  localparam logic [30:0] V_EXR_SUB =
    pk(9'b000000100, 2'd1, 3'd0, 3'd2, 3'd0, 2'd0, 2'd0, 3'd0, 4'd0);
  localparam logic [30:0] V_EXR_AND =
    pk(9'b000000100, 2'd1, 3'd0, 3'd3, 3'd0, 2'd0, 2'd0, 3'd0, 4'd0);
  localparam logic [30:0] V_WBR =
    pk(9'b000100000, 2'd0, 3'd0, 3'd0, 3'd0, 2'd0, 2'd0, 3'd1, 4'd0);
  localparam logic [30:0] V_EXI =
    pk(9'b000000100, 2'd1, 3'd2, 3'd1, 3'd0, 2'd0, 2'd0, 3'd0, 4'd0);
  localparam logic [30:0] V_MRD_W =
    pk(9'b000000000, 2'd0, 3'd0, 3'd0, 3'd0, 2'd1, 2'd0, 3'd0, 4'd0);
  localparam logic [30:0] V_MRD_L =
    pk(9'b000000010, 2'd0, 3'd0, 3'd0, 3'd0, 2'd1, 2'd0, 3'd0, 4'd0);
  localparam logic [30:0] V_WBL =
    pk(9'b000100000, 2'd0, 3'd0, 3'd0, 3'd0, 2'd0, 2'd0, 3'd0, 4'd1);
  localparam logic [30:0] V_MWR =
    pk(9'b001000000, 2'd0, 3'd0, 3'd0, 3'd0, 2'd1, 2'd0, 3'd0, 4'd0);
  localparam logic [30:0] V_BEQ0 =
    pk(9'b000000000, 2'd1, 3'd0, 3'd2, 3'd1, 2'd0, 2'd0, 3'd0, 4'd0);
  localparam logic [30:0] V_BEQ1 =
    pk(9'b100000000, 2'd1, 3'd0, 3'd2, 3'd1, 2'd0, 2'd0, 3'd0, 4'd0);
  localparam logic [30:0] V_JMP =
    pk(9'b100000000, 2'd0, 3'd0, 3'd0, 3'd2, 2'd0, 2'd0, 3'd0, 4'd0);
  localparam logic [30:0] V_EXC0 =
    pk(9'b000000001, 2'd0, 3'd1, 3'd2, 3'd0, 2'd0, 2'd0, 3'd0, 4'd0);
  localparam logic [30:0] V_EXC1 =
    pk(9'b000000001, 2'd0, 3'd1, 3'd2, 3'd0, 2'd0, 2'd1, 3'd0, 4'd0);
  localparam logic [30:0] V_XRW0 =
    pk(9'b000000000, 2'd0, 3'd0, 3'd0, 3'd0, 2'd2, 2'd0, 3'd0, 4'd0);
  localparam logic [30:0] V_XRL0 =
    pk(9'b000000010, 2'd0, 3'd0, 3'd0, 3'd0, 2'd2, 2'd0, 3'd0, 4'd0);
  localparam logic [30:0] V_XRW1 =
    pk(9'b000000000, 2'd0, 3'd0, 3'd0, 3'd0, 2'd2, 2'd1, 3'd0, 4'd0);
  localparam logic [30:0] V_XRL1 =
    pk(9'b000000010, 2'd0, 3'd0, 3'd0, 3'd0, 2'd2, 2'd1, 3'd0, 4'd0);
  localparam logic [30:0] V_XJ =
    pk(9'b100000000, 2'd0, 3'd0, 3'd0, 3'd3, 2'd0, 2'd0, 3'd0, 4'd0);

  task automatic check(input string tag,
                       input logic [30:0] got,
                       input logic [30:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Called at a falling edge: settle, compare, move to the next one.
  task automatic cyc(input string tag, input logic [30:0] exp);
    #1;
    check(tag, o1, exp);
    @(negedge clock);
  endtask

  task automatic cyc2(input string tag, input logic [30:0] exp);
    #1;
    check(tag, o2, exp);
    @(negedge clock);
  endtask

  task automatic fetch1(input string tag);
    cyc({tag, "_f0"}, V_ZERO);
    cyc({tag, "_f1"}, V_ZERO);
    cyc({tag, "_fl"}, V_FL);
    cyc({tag, "_dec"}, V_DEC);
  endtask

  initial begin
    @(negedge clock);
    cyc("rst_hold1", V_ZERO);
    check("rst_hold2", o2, V_ZERO);
    reset = 1'b0;
    cyc("rst_cyc", V_ZERO);
    fetch1("add");
    cyc("add_exr", V_EXR_ADD);
    cyc("add_wbr", V_WBR);

    fetch1("add2");
    reset = 1'b1;
    cyc("midrst_async", V_ZERO);
    cyc("midrst_hold", V_ZERO);
    reset = 1'b0;
    cyc("midrst_cyc", V_ZERO);
    fetch1("post_rst");
    cyc("post_rst_exr", V_EXR_ADD);
    cyc("post_rst_wbr", V_WBR);

    reset = 1'b1;
    Opcode = 6'h23;
    cyc2("lw_rst", V_ZERO);
    reset = 1'b0;
    cyc2("lw_rcyc", V_ZERO);
    cyc2("lw_f0", V_ZERO);
    cyc2("lw_f1", V_ZERO);
    cyc2("lw_f2", V_ZERO);
    cyc2("lw_fl", V_FL);
    cyc2("lw_dec", V_DEC);
    cyc2("lw_addr", V_EXI);
    cyc2("lw_mrd0", V_MRD_W);
    cyc2("lw_mrd1", V_MRD_W);
    cyc2("lw_mrd2", V_MRD_L);
    cyc2("lw_wbl", V_WBL);
    cyc2("lw_fetch", V_ZERO);

    reset = 1'b1;
    Opcode = 6'h04;
    Zero = 1'b0;
    cyc("beq_rst", V_ZERO);
    reset = 1'b0;
    cyc("beq_rcyc", V_ZERO);
    fetch1("beq0");
    cyc("beq0_beq", V_BEQ0);
    cyc("beq1_f0", V_ZERO);
    cyc("beq1_f1", V_ZERO);
    cyc("beq1_fl", V_FL);
    Zero = 1'b1;
    cyc("beq1_dec_zero", V_DEC);
    cyc("beq1_beq", V_BEQ1);
    Zero = 1'b0;

    Opcode = 6'h08;
    fetch1("addi");
    Overflow = 1'b1;
    cyc("addi_exi", V_EXI);
    Overflow = 1'b0;
    cyc("addi_exc", V_EXC1);
    cyc("addi_xrw", V_XRW1);
    cyc("addi_xrl", V_XRL1);
    cyc("addi_xj", V_XJ);

    Opcode = 6'h3F;
    fetch1("badop");
    cyc("badop_exc", V_EXC0);
    cyc("badop_xrw", V_XRW0);
    cyc("badop_xrl", V_XRL0);
    cyc("badop_xj", V_XJ);

    Opcode = 6'h00;
    Funct = 6'h21;
    fetch1("badfn");
    cyc("badfn_exc", V_EXC0);
    cyc("badfn_xrw", V_XRW0);
    cyc("badfn_xrl", V_XRL0);
    cyc("badfn_xj", V_XJ);

    Funct = 6'h24;
    fetch1("and");
    Overflow = 1'b1;
    cyc("and_exr", V_EXR_AND);
    Overflow = 1'b0;
    cyc("and_wbr", V_WBR);

    Funct = 6'h22;
    fetch1("subov");
    Overflow = 1'b1;
    cyc("subov_exr", V_EXR_SUB);
    Overflow = 1'b0;
    cyc("subov_exc", V_EXC1);
    cyc("subov_xrw", V_XRW1);
    cyc("subov_xrl", V_XRL1);
    cyc("subov_xj", V_XJ);

    Opcode = 6'h2B;
    fetch1("sw");
    Overflow = 1'b1;
    cyc("sw_addr", V_EXI);
    Overflow = 1'b0;
    cyc("sw_mwr", V_MWR);

    Opcode = 6'h02;
    fetch1("j");
    cyc("j_jmp", V_JMP);
    cyc("j_fetch", V_ZERO);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Moore-style FSM that sequences the multicycle CPU datapath.
- Consumes IR fields and ALU flags; drives every register write-enable, mux select and ALU operation the datapath needs.
- Supports add, sub, and, addi, lw, sw, beq and j.
- Handles two exceptions: invalid opcode and arithmetic overflow.
- Instantiated beside the datapath inside the CPU top; sole source of datapath control.

Parameters:
MEM_WAIT, 1, extra idle cycles between presenting a memory address and memory data being valid (0..3).

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high
Opcode  input  6  IR[31:26]
Funct  input  6  IR[5:0]
Zero  input  1  ALU result == 0
Overflow  input  1  ALU signed overflow, current cycle
PCWrite  output  1  PC load
IRWrite  output  1  IR load
MemWrite  output  1  memory write strobe
RegWrite  output  1  register-bank write
RegAWrite  output  1  A load
RegBWrite  output  1  B load
RegALUOutWrite  output  1  ALUOut load
RegMDRWrite  output  1  MDR load
RegEPCWrite  output  1  EPC load
ALUSrcA  output  2  0=PC, 1=A
ALUSrcB  output  3  0=B, 1=const 4, 2=sext(imm), 3=sext(imm)<<2
ALUControl  output  3  0=pass A, 1=add, 2=sub, 3=and
PCSource  output  3  0=ALU result, 1=ALUOut, 2=jump target, 3=MDR
MemAdd  output  2  0=PC, 1=ALUOut, 2=exception vector
ExceptionAddress  output  2  0=opcode vector (254), 1=overflow vector (255)
RegDest  output  3  0=rt, 1=rd
RegData  output  4  0=ALUOut, 1=MDR

Behaviour:
- Reset: asynchronous. Reset enters RESET immediately; every output is 0 while reset is high and while in RESET.
- Reset mid-instruction: aborts at once; no write-enable may pulse afterwards.
- RESET lasts one cycle, then goes to FETCH.
- Outputs are a function of the state only. Any signal not listed for a state is 0.
- Write-enables are single-cycle pulses.

Wait counter:
- A 2-bit counter implements MEM_WAIT.
- Loaded on entry to any memory-access state.
- The state holds until the counter reaches 0.
- MEM_WAIT=0: exactly one cycle in the wait state.

States:
- FETCH: MemAdd=0 for 1+MEM_WAIT cycles.
- FETCH_LATCH: MemAdd=0, IRWrite=1, ALUSrcA=0, ALUSrcB=1, ALUControl=1, PCSource=0, PCWrite=1.
- DECODE: RegAWrite=RegBWrite=1, ALUSrcA=0, ALUSrcB=3, ALUControl=1, RegALUOutWrite=1 (branch target). Dispatch on Opcode:
  - 0x00 with Funct 0x20/0x22/0x24 -> EXEC_R
  - 0x08 -> EXEC_I
  - 0x23 or 0x2B -> ADDR
  - 0x04 -> BEQ
  - 0x02 -> JUMP
  - anything else (including an unknown Funct) -> EXC with ExceptionAddress=0
- EXEC_R: ALUSrcA=1, ALUSrcB=0, ALUControl per Funct (0x20->1, 0x22->2, 0x24->3), RegALUOutWrite=1.
  - Overflow=1 and Funct!=0x24 -> EXC with ExceptionAddress=1.
  - Otherwise -> WB_R.
- WB_R: RegDest=1, RegData=0, RegWrite=1 -> FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=2, ALUControl=1, RegALUOutWrite=1.
  - Overflow -> EXC (ExceptionAddress=1).
  - Otherwise -> WB_I.
- WB_I: RegDest=0, RegData=0, RegWrite=1 -> FETCH.
- ADDR: ALUSrcA=1, ALUSrcB=2, ALUControl=1, RegALUOutWrite=1. Overflow is ignored. lw -> MEM_RD; sw -> MEM_WR.
- MEM_RD: MemAdd=1 for 1+MEM_WAIT cycles, then RegMDRWrite=1 on the final cycle -> WB_L.
- WB_L: RegDest=0, RegData=1, RegWrite=1 -> FETCH.
- MEM_WR: MemAdd=1, MemWrite=1 for one cycle -> FETCH.
- BEQ: ALUSrcA=1, ALUSrcB=0, ALUControl=2, PCSource=1, PCWrite=Zero -> FETCH.
- JUMP: PCSource=2, PCWrite=1 -> FETCH.

Exception sequence:
- EXC: ALUSrcA=0, ALUSrcB=1, ALUControl=2, RegEPCWrite=1 (EPC = PC-4).
- EXC_RD: MemAdd=2 for 1+MEM_WAIT cycles, RegMDRWrite=1 on the final cycle.
- EXC_JMP: PCSource=3, PCWrite=1 -> FETCH.
- An internal exception-cause register is captured on the transition into EXC. It holds ExceptionAddress stable through EXC_RD.
- RegWrite is never asserted on any exception path. The destination register is left unchanged.

Other rules:
- Simultaneous Overflow with a non-arithmetic state: ignored.
- Zero is only sampled in BEQ.

Test Plan:
- Reset asserted during EXEC_R, then released -> all outputs 0 for the reset duration plus one cycle; first FETCH_LATCH pulses PCWrite and IRWrite once.
- add (Opcode 0, Funct 0x20), MEM_WAIT=1, Overflow=0 -> FETCH 2 cycles, FETCH_LATCH, DECODE, EXEC_R, WB_R; RegWrite=1 with RegDest=1 exactly once; 6 cycles total.
- lw (0x23), MEM_WAIT=2 -> MEM_RD holds MemAdd=1 for 3 cycles; RegMDRWrite pulses on the 3rd; WB_L shows RegData=1, RegDest=0.
- beq with Zero=0, then with Zero=1 -> PCWrite=0 and PCWrite=1 respectively in BEQ, with PCSource=1.
- addi with Overflow=1 in EXEC_I -> RegEPCWrite=1 in EXC; ExceptionAddress=1 through EXC_RD; PCSource=3 with PCWrite in EXC_JMP; RegWrite never pulses.
- Opcode 0x3F -> DECODE goes straight to EXC with ExceptionAddress=0; MemAdd=2 in EXC_RD; then returns to FETCH.
